// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with a one-entry skid buffer.
// Registered in_ready, in-order payload flow, flush and stall counter.
module id_ex_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [DATA_W-1:0] in_operand1,
  input  logic [DATA_W-1:0] in_operand2,
  input  logic [DATA_W-1:0] in_s_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_op,
  output logic [4:0]        out_rd,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [DATA_W-1:0] out_operand1,
  output logic [DATA_W-1:0] out_operand2,
  output logic [DATA_W-1:0] out_s_data,
  output logic              out_illegal,
  output logic [15:0]       stall_cnt
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  typedef struct packed {
    logic [6:0]        op;
    logic [4:0]        rd;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] s;
    logic              ill;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  ent_t        r_main;
  ent_t        r_skid;
  ent_t        w_in;
  logic        r_main_v;
  logic        r_skid_v;
  logic        r_in_ready;
  logic [15:0] r_stall;
  logic        w_ill;
  logic        w_acc;
  logic        w_con;
  logic        w_ld_main_in;
  logic        w_ld_main_skid;
  logic        w_ld_skid;
  logic        w_clr_main;
  logic        w_clr_skid;

  assign w_acc = in_valid & r_in_ready;
  assign w_con = r_main_v & out_ready;

  // Flag opcodes outside the supported decode set.
  always_comb begin
    w_ill = 1'b1;
    case (in_op)
      OP_R, OP_I, OP_L, OP_S, OP_B: w_ill = 1'b0;
      default:                      w_ill = 1'b1;
    endcase
  end

  // Bundle the incoming payload with its illegal flag.
  always_comb begin
    w_in     = '0;
    w_in.op  = in_op;
    w_in.rd  = in_rd;
    w_in.f3  = in_funct3;
    w_in.f7  = in_funct7;
    w_in.a   = in_operand1;
    w_in.b   = in_operand2;
    w_in.s   = in_s_data;
    w_in.ill = w_ill;
  end

  // Next state and entry load/clear strobes.
  always_comb begin
    w_nxt          = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    w_clr_main     = 1'b0;
    w_clr_skid     = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_ld_main_in = 1'b1;
          w_nxt        = BUSY;
        end
      end
      BUSY: begin
        if (w_acc && w_con) begin
          w_ld_main_in = 1'b1;
        end else if (w_acc) begin
          w_ld_skid = 1'b1;
          w_nxt     = FULL;
        end else if (w_con) begin
          w_clr_main = 1'b1;
          w_nxt      = EMPTY;
        end
      end
      FULL: begin
        if (w_con) begin
          w_ld_main_skid = 1'b1;
          w_clr_skid     = 1'b1;
          w_nxt          = BUSY;
        end
      end
      default: begin
        w_clr_main = 1'b1;
        w_clr_skid = 1'b1;
        w_nxt      = EMPTY;
      end
    endcase
  end

  // State, valid bits, registered ready and both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b0;
    end else if (flush) begin
      r_state    <= EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_nxt;
      r_main_v   <= (w_nxt != EMPTY);
      r_skid_v   <= (w_nxt == FULL);
      r_in_ready <= (w_nxt != FULL);
      if (w_ld_main_in) begin
        r_main <= w_in;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end else if (w_clr_main) begin
        r_main <= '0;
      end
      if (w_ld_skid) begin
        r_skid <= w_in;
      end else if (w_clr_skid) begin
        r_skid <= '0;
      end
    end
  end

  // Saturating count of cycles where EX holds off a valid payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (r_main_v && !out_ready && r_stall != 16'hFFFF) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_main_v;
  assign out_op       = r_main.op;
  assign out_rd       = r_main.rd;
  assign out_funct3   = r_main.f3;
  assign out_funct7   = r_main.f7;
  assign out_operand1 = r_main.a;
  assign out_operand2 = r_main.b;
  assign out_s_data   = r_main.s;
  assign out_illegal  = r_main.ill;
  assign stall_cnt    = r_stall;

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed bench for id_ex_skid.
// Drives/samples 1 time unit after each rising edge.
module tb_id_ex_skid;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_LU = 7'b0110111;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_op;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_operand1;
  logic [31:0] in_operand2;
  logic [31:0] in_s_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_op;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_operand1;
  logic [31:0] out_operand2;
  logic [31:0] out_s_data;
  logic        out_illegal;
  logic [15:0] stall_cnt;

  int checks;
  int failures;

  id_ex_skid #(.DATA_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_rd(in_rd),
    .in_funct3(in_funct3),
    .in_funct7(in_funct7),
    .in_operand1(in_operand1),
    .in_operand2(in_operand2),
    .in_s_data(in_s_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_op(out_op),
    .out_rd(out_rd),
    .out_funct3(out_funct3),
    .out_funct7(out_funct7),
    .out_operand1(out_operand1),
    .out_operand2(out_operand2),
    .out_s_data(out_s_data),
    .out_illegal(out_illegal),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [6:0] op,
                       input logic [4:0] rd);
    in_valid    = v;
    in_op       = op;
    in_rd       = rd;
    in_funct3   = rd[2:0];
    in_funct7   = {2'b0, rd};
    in_operand1 = 32'h100 + 32'(rd);
    in_operand2 = 32'h200 + 32'(rd);
    in_s_data   = 32'h300 + 32'(rd);
  endtask

  task automatic idle();
    drive(1'b0, 7'd0, 5'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_rd", out_rd, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, OP_R, 5'(i));
      step();
      check("str_valid", out_valid, 1);
      check("str_rd", out_rd, 64'(i));
      check("str_op1", out_operand1, 64'(32'h100 + i));
      check("str_ready", in_ready, 1);
      check("str_ill", out_illegal, 0);
    end
    idle();
    step();
    check("str_drain_v", out_valid, 0);
    check("str_drain_rd", out_rd, 0);
    check("str_stall", stall_cnt, 0);

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, OP_R, 5'd3);
    step();
    check("bp_rd3", out_rd, 3);
    check("bp_ready1", in_ready, 1);
    drive(1'b1, OP_R, 5'd4);
    step();
    check("bp_full_ready", in_ready, 0);
    check("bp_full_rd", out_rd, 3);
    drive(1'b1, OP_R, 5'd5);
    step();
    check("bp_hold_rd", out_rd, 3);
    check("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    check("bp_rd4", out_rd, 4);
    check("bp_rd4_sd", out_s_data, 32'h304);
    check("bp_ready2", in_ready, 1);
    step();
    check("bp_rd5", out_rd, 5);
    check("bp_v5", out_valid, 1);
    idle();
    step();
    check("bp_drain", out_valid, 0);
    check("bp_stall", stall_cnt, 2);

    // flush in FULL
    out_ready = 1'b0;
    drive(1'b1, OP_R, 5'd10);
    step();
    drive(1'b1, OP_R, 5'd11);
    step();
    check("fl_full", in_ready, 0);
    check("fl_stall", stall_cnt, 3);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, OP_R, 5'd9);
    step();
    flush = 1'b0;
    idle();
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    check("fl_rd", out_rd, 0);
    check("fl_op1", out_operand1, 0);
    check("fl_op", out_op, 0);
    step();
    check("fl_no9", out_valid, 0);
    check("fl_stall2", stall_cnt, 3);

    // illegal flag
    out_ready = 1'b0;
    drive(1'b1, OP_LU, 5'd2);
    step();
    check("ill_v", out_valid, 1);
    check("ill_flag", out_illegal, 1);
    check("ill_op", out_op, 64'(OP_LU));
    out_ready = 1'b1;
    drive(1'b1, OP_L, 5'd6);
    step();
    check("ld_rd", out_rd, 6);
    check("ld_flag", out_illegal, 0);
    idle();
    step();
    check("ld_drain", out_valid, 0);

    // async reset mid-cycle in FULL
    out_ready = 1'b0;
    drive(1'b1, OP_R, 5'd12);
    step();
    drive(1'b1, OP_LU, 5'd13);
    step();
    idle();
    check("ar_full", in_ready, 0);
    check("ar_stall_pre", stall_cnt, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_rd", out_rd, 0);
    check("ar_op1", out_operand1, 0);
    check("ar_ready", in_ready, 0);
    check("ar_stall", stall_cnt, 0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_rel_ready", in_ready, 1);
    check("ar_rel_valid", out_valid, 0);

    // saturation
    out_ready = 1'b0;
    drive(1'b1, OP_R, 5'd7);
    step();
    idle();
    check("sat_start", stall_cnt, 0);
    repeat (100) step();
    check("sat_100", stall_cnt, 100);
    repeat (69900) step();
    check("sat_max", stall_cnt, 16'hFFFF);
    repeat (10) step();
    check("sat_hold", stall_cnt, 16'hFFFF);
    check("sat_rd", out_rd, 7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sat_flush", stall_cnt, 16'hFFFF);
    check("sat_flush_v", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_skid.md
ID_EX_SKID -- requirements
Module: id_ex_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of operand1/operand2/s_data paths.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  synchronous pipeline kill from branch/hazard logic.
REQ-005 in_valid  input  1  decode-side payload valid.
REQ-006 in_ready  output  1  block can accept a payload this cycle.
REQ-007 in_op / in_rd / in_funct3 / in_funct7  input  7/5/3/7  decoded opcode and fields.
REQ-008 in_operand1 / in_operand2 / in_s_data  input  DATA_W each  operand-select results from decode.
REQ-009 out_valid  output  1  EX-side payload valid.
REQ-010 out_ready  input  1  EX stage consumes payload this cycle.
REQ-011 out_op / out_rd / out_funct3 / out_funct7 / out_operand1 / out_operand2 / out_s_data  output  same widths  registered payload.
REQ-012 out_illegal  output  1  registered flag: accepted op not in {R_TYPE, I_IMM, I_LOAD, S_TYPE, B_TYPE}.
REQ-013 stall_cnt  output  16  saturating count of backpressure cycles.

Function
REQ-014 Storage SHALL be two entries: main (drives out_*) and skid; states EMPTY (none valid), BUSY (main only), FULL (main+skid).
REQ-015 Accept = in_valid & in_ready; consume = out_valid & out_ready.
REQ-016 in_ready SHALL equal NOT skid_valid, driven from a register (no combinational path from out_ready).
REQ-017 out_valid SHALL equal main_valid; all out_* SHALL be direct register outputs.
REQ-018 EMPTY: accept -> load main, go BUSY; else stay.
REQ-019 BUSY: accept & consume -> reload main with input, stay BUSY; accept only -> load skid, go FULL; consume only -> go EMPTY; neither -> hold.
REQ-020 FULL: in_ready=0; consume -> main <= skid, go BUSY; else hold both entries unchanged.
REQ-021 Latency: payload accepted on edge N SHALL appear on out_* after edge N, one cycle; sustained throughput one payload per cycle while out_ready=1.
REQ-022 Payload order SHALL be preserved; no payload duplicated or dropped absent flush.
REQ-023 out_illegal SHALL be computed from the input op at accept and travel with its payload (main and skid each hold a copy).
REQ-024 flush=1 SHALL, at the next edge, clear main_valid and skid_valid, zero all stored payload and illegal flags, go EMPTY; flush overrides simultaneous accept and consume (input that cycle discarded).
REQ-025 Payload registers of an invalid entry SHALL read zero (out_* = 0 whenever out_valid=0).
REQ-026 stall_cnt SHALL increment by 1 each cycle out_valid=1 & out_ready=0, saturate at 16'hFFFF, never wrap; flush does not clear it.
REQ-027 out_ready while out_valid=0 SHALL have no effect.
REQ-028 Holding payload while in_valid=1 & in_ready=0 is the upstream's duty; block samples input only on accept.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force state EMPTY, out_valid=0, skid_valid=0, all payload and out_illegal=0, stall_cnt=0, in_ready=0.
REQ-030 First rising edge after rst_n deasserts SHALL leave in_ready=1 (EMPTY), no accept occurring on that edge's preceding reset-low interval.
REQ-031 Reset asserted mid-operation (BUSY or FULL) SHALL discard both entries with no partial output.

Verification
REQ-032 Streaming: out_ready=1, feed R_TYPE ops rd=1..8 back-to-back -> out rd=1..8 on consecutive cycles, 1-cycle latency, in_ready never 0.
REQ-033 Backpressure: out_ready=0, send rd=3 then rd=4 -> FULL, in_ready=0, rd=5 held; raise out_ready -> outputs rd=3,4,5 in order, stall_cnt equals low-ready cycles with out_valid=1.
REQ-034 Flush in FULL with simultaneous in_valid (rd=9) -> next cycle out_valid=0, in_ready=1, out_* all zero, rd=9 never appears.
REQ-035 Illegal op: accept op=7'b0110111 -> out_illegal=1 with that payload; following I_LOAD -> out_illegal=0.
REQ-036 Async reset: assert rst_n=0 mid-clock in FULL -> outputs zero before next edge; stall_cnt=0.
REQ-037 Saturation: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF, stays there.
